// File: rtl/code_entry.sv
// Keypad front end: synchronizes and debounces the 0/1/clear keys, assembles a CODE_W-bit
// code MSB-first, queries the code-check database and reports grant/deny with failure lockout.
module code_entry #(
    parameter int CODE_W          = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int RESULT_LAT      = 1,
    parameter int MAX_FAILS       = 3,
    parameter int LOCK_CYCLES     = 5000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          key0_raw,
    input  logic                          key1_raw,
    input  logic                          clr_raw,
    input  logic                          match_in,
    output logic [CODE_W-1:0]             code,
    output logic                          enable,
    output logic                          granted,
    output logic                          denied,
    output logic                          locked,
    output logic                          busy,
    output logic [$clog2(CODE_W+1)-1:0]   digit_cnt,
    output logic [2:0]                    state_dbg
);

    localparam int DW     = $clog2(CODE_W + 1);
    localparam int DBW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int FW     = $clog2(MAX_FAILS + 1);
    localparam int TM_A   = (LOCK_CYCLES > TIMEOUT_CYCLES) ? LOCK_CYCLES : TIMEOUT_CYCLES;
    localparam int TM_MAX = (TM_A > RESULT_LAT) ? TM_A : RESULT_LAT;
    localparam int TMW    = $clog2(TM_MAX + 1);

    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMW-1:0] TO_LAST = TMW'(TIMEOUT_CYCLES - 1);
    localparam logic [TMW-1:0] LK_LAST = TMW'(LOCK_CYCLES - 1);
    localparam logic [TMW-1:0] RL_CYC  = TMW'(RESULT_LAT);
    localparam logic [DW-1:0]  FULL    = DW'(CODE_W);
    localparam logic [FW-1:0]  MF_LAST = FW'(MAX_FAILS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        CHECK   = 3'd2,
        WAIT    = 3'd3,
        GRANT   = 3'd4,
        DENY    = 3'd5,
        LOCKED  = 3'd6
    } state_t;

    // ---------------- key input path: sync -> debounce -> rising-edge event ----------------
    // Bit order in the key vectors: [0] = key0, [1] = key1, [2] = clear.
    logic [2:0]     raw_vec, sync1, sync2, lvl, lvl_q, press;
    logic [DBW-1:0] dcnt [3];

    assign raw_vec = {clr_raw, key1_raw, key0_raw};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            lvl   <= '0;
            lvl_q <= '0;
            for (int i = 0; i < 3; i++) dcnt[i] <= '0;
        end else begin
            sync1 <= raw_vec;
            sync2 <= sync1;
            lvl_q <= lvl;
            // dcnt counts consecutive samples that disagree with the accepted level
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == lvl[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DB_LAST) begin
                    lvl[i]  <= sync2[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

    assign press = lvl & ~lvl_q;

    logic clr_ev, bit_ev, bit_val;
    assign clr_ev  = press[2];
    assign bit_ev  = ~clr_ev & (press[0] ^ press[1]);
    assign bit_val = press[1];

    // ---------------- control FSM ----------------
    // Database handshake: enable is high for exactly one cycle (CHECK) with code already
    // stable; match_in is sampled RESULT_LAT cycles after that cycle, and code is held
    // unchanged from CHECK until the sample has been taken.
    state_t         state, state_n;
    logic [CODE_W-1:0] code_n;
    logic [DW-1:0]  cnt_n;
    logic [TMW-1:0] tmr, tmr_n;
    logic [FW-1:0]  fails, fails_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            code      <= '0;
            digit_cnt <= '0;
            tmr       <= '0;
            fails     <= '0;
        end else begin
            state     <= state_n;
            code      <= code_n;
            digit_cnt <= cnt_n;
            tmr       <= tmr_n;
            fails     <= fails_n;
        end
    end

    always_comb begin
        state_n = state;
        code_n  = code;
        cnt_n   = digit_cnt;
        tmr_n   = tmr;
        fails_n = fails;
        enable  = 1'b0;
        granted = 1'b0;
        denied  = 1'b0;
        locked  = 1'b0;
        busy    = (state != IDLE);

        case (state)
            IDLE, COLLECT: begin
                if (clr_ev) begin
                    // clear is meaningless with nothing entered, so IDLE just stays put
                    code_n  = '0;
                    cnt_n   = '0;
                    tmr_n   = '0;
                    state_n = IDLE;
                end else if (bit_ev) begin
                    code_n  = {code[CODE_W-2:0], bit_val};
                    cnt_n   = digit_cnt + 1'b1;
                    tmr_n   = '0;
                    state_n = (cnt_n == FULL) ? CHECK : COLLECT;
                end else if (state == COLLECT) begin
                    if (tmr == TO_LAST) begin
                        code_n  = '0;
                        cnt_n   = '0;
                        tmr_n   = '0;
                        state_n = IDLE;
                    end else begin
                        tmr_n = tmr + 1'b1;
                    end
                end
            end
            CHECK: begin
                enable  = 1'b1;
                tmr_n   = TMW'(1);
                state_n = WAIT;
            end
            WAIT: begin
                if (tmr == RL_CYC) begin
                    tmr_n   = '0;
                    state_n = match_in ? GRANT : DENY;
                end else begin
                    tmr_n = tmr + 1'b1;
                end
            end
            GRANT: begin
                granted = 1'b1;
                fails_n = '0;
                code_n  = '0;
                cnt_n   = '0;
                state_n = IDLE;
            end
            DENY: begin
                denied = 1'b1;
                code_n = '0;
                cnt_n  = '0;
                tmr_n  = '0;
                if (fails == MF_LAST) begin
                    fails_n = '0;
                    state_n = LOCKED;
                end else begin
                    fails_n = fails + 1'b1;
                    state_n = IDLE;
                end
            end
            LOCKED: begin
                locked = 1'b1;
                if (tmr == LK_LAST) begin
                    tmr_n   = '0;
                    state_n = IDLE;
                end else begin
                    tmr_n = tmr + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign state_dbg = state;

endmodule
